fpga_dffer_pipe: RTL and testbench
==================================

# fpga_dffer_pipe

Parametrised clock-enabled register pipeline with asynchronous reset. It generalises the single-bit enable flip-flop to a WIDTH-bit, DEPTH-stage delay line with per-stage valid tracking, synchronous flush, a runtime-selectable tap and an occupancy count. It is the team's standard primitive for retiming and fixed-latency alignment of datapath signals in the FPGA fabric wherever a stall (enable) must freeze the whole line.

## Interface
- WIDTH, default 8: data width in bits, ≥1.
- DEPTH, default 4: number of register stages, ≥1.
- RESET_VAL, default '0: WIDTH-bit value loaded into every data stage on reset and on flush.
- clk_i  in  1: clock; all state changes on its rising edge.
- reset_i  in  1: asynchronous reset, active-high; asserting it clears state immediately, deassertion is synchronous to clk_i by the integrator.
- E_i  in  1: clock enable; the line advances only when 1.
- clr_i  in  1: synchronous flush.
- D_i  in  WIDTH: data into stage 0.
- valid_i  in  1: valid qualifier travelling with D_i.
- tap_sel_i  in  clog2(DEPTH) (min 1): selects the stage driven on tap_o.
- Q_o  out  WIDTH: stage DEPTH-1 data.
- valid_o  out  1: stage DEPTH-1 valid.
- tap_o  out  WIDTH: data of stage tap_sel_i.
- tap_valid_o  out  1: valid of stage tap_sel_i.
- fill_o  out  clog2(DEPTH+1): number of stages currently holding valid=1.

## Operation
- State: data[0..DEPTH-1] (WIDTH each), vld[0..DEPTH-1], fill counter.
- Reset (reset_i=1, asynchronous): every data stage = RESET_VAL, every vld = 0, fill = 0. Hence Q_o = RESET_VAL, valid_o = 0, fill_o = 0, tap_o = RESET_VAL, tap_valid_o = 0 while in reset.
- Priority per rising edge: reset_i > clr_i > E_i > hold.
- clr_i=1: all data = RESET_VAL, all vld = 0, fill = 0, regardless of E_i, D_i and valid_i; the input word presented that cycle is discarded.
- E_i=1, clr_i=0: data[0] <= D_i, vld[0] <= valid_i, data[k] <= data[k-1], vld[k] <= vld[k-1] for k ≥ 1; fill <= fill + valid_i − vld[DEPTH-1].
- E_i=0, clr_i=0: all state holds, with D_i and valid_i ignored.
- Data of invalid stages still shifts. Valid is a qualifier only and never gates data movement.
- fill arithmetic: width clog2(DEPTH+1). The count cannot exceed DEPTH or go below 0 by construction. The simultaneous entry of valid_i=1 and exit of vld[DEPTH-1]=1 leaves fill unchanged.
- Tap: combinational mux from registered stages. tap_sel_i ≥ DEPTH (possible when DEPTH is not a power of 2) returns tap_o = RESET_VAL, tap_valid_o = 0.
- DEPTH=1: tap_sel_i is 1 bit, and tap_sel_i=1 is out of range. fill_o is 1 bit.

## Timing
- Latency D_i→Q_o is exactly DEPTH enabled edges. Disabled cycles add no latency, so a word reaches Q_o after its DEPTH-th E_i=1 edge.
- Q_o, valid_o and fill_o are registered with no combinational input-to-output path. tap_o and tap_valid_o are combinational from tap_sel_i only.
- Flush takes effect at the edge where clr_i=1 and outputs show the flushed values the following cycle. There is no multi-cycle flush state.
- A reset asserted mid-stream clears all stages asynchronously, including any partially filled line. The first edge after deassertion behaves as a normal edge.
- Throughput is 1 word per enabled cycle with no bubbles inserted.

## Test plan
- Reset: WIDTH=8, DEPTH=4, RESET_VAL=8'hA5. Assert reset_i mid-cycle -> Q_o=8'hA5, valid_o=0, fill_o=0 immediately, without waiting for a clock edge.
- Streaming: E_i=1, valid_i=1, D_i=8'h01,02,03,04,05 on consecutive edges -> Q_o=8'h01 with valid_o=1 after edge 4, then 02 and 03 on subsequent edges; fill_o=1,2,3,4,4.
- Stall: load 8'h11, then E_i=0 for 3 cycles with D_i toggling, then E_i=1 -> Q_o=8'h11 after the 4th enabled edge (7 edges total), and no toggled D_i value appears in any stage.
- Flush priority: fill to fill_o=4, then clr_i=1 with E_i=1, valid_i=1, D_i=8'hFF -> next cycle all stages 8'hA5, valid_o=0, fill_o=0.
- Mixed valid: valid_i pattern 1,0,1,1,0,... with E_i=1 -> valid_o reproduces the pattern delayed by 4 enabled edges, and fill_o always equals the popcount of the last 4 valid_i values.
- Tap: DEPTH=3 build, line holding 8'h0A,0B,0C in stages 0..2 -> tap_sel_i=0,1,2 yields 0A,0B,0C; tap_sel_i=3 yields 8'hA5 with tap_valid_o=0.

Source files
------------

// File: rtl/fpga_dffer_pipe.sv
// Clock-enabled WIDTH x DEPTH delay line with per-stage valid, synchronous flush,
// runtime-selectable tap and occupancy count. A low E_i freezes the whole line.
module fpga_dffer_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               TAP_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int               FILL_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              E_i,
    input  logic              clr_i,
    input  logic [WIDTH-1:0]  D_i,
    input  logic              valid_i,
    input  logic [TAP_W-1:0]  tap_sel_i,
    output logic [WIDTH-1:0]  Q_o,
    output logic              valid_o,
    output logic [WIDTH-1:0]  tap_o,
    output logic              tap_valid_o,
    output logic [FILL_W-1:0] fill_o
);

    logic [WIDTH-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [FILL_W-1:0] fill_q;

    // One word in and one out on the same edge cancel; the count never wraps.
    function automatic logic [FILL_W-1:0] fill_next(input logic [FILL_W-1:0] cur,
                                                    input logic entering,
                                                    input logic leaving);
        return cur + FILL_W'(entering) - FILL_W'(leaving);
    endfunction

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < DEPTH; k++) data_q[k] <= RESET_VAL;
            vld_q  <= '0;
            fill_q <= '0;
        end else if (clr_i) begin
            for (int k = 0; k < DEPTH; k++) data_q[k] <= RESET_VAL;
            vld_q  <= '0;
            fill_q <= '0;
        end else if (E_i) begin
            // Data moves regardless of valid; valid is only a qualifier.
            data_q[0] <= D_i;
            vld_q[0]  <= valid_i;
            for (int k = 1; k < DEPTH; k++) begin
                data_q[k] <= data_q[k-1];
                vld_q[k]  <= vld_q[k-1];
            end
            fill_q <= fill_next(fill_q, valid_i, vld_q[DEPTH-1]);
        end
    end

    assign Q_o     = data_q[DEPTH-1];
    assign valid_o = vld_q[DEPTH-1];
    assign fill_o  = fill_q;

    // Out-of-range selects (non power-of-2 DEPTH) read as an empty reset stage.
    always_comb begin
        tap_o       = RESET_VAL;
        tap_valid_o = 1'b0;
        if (int'(tap_sel_i) < DEPTH) begin
            tap_o       = data_q[tap_sel_i];
            tap_valid_o = vld_q[tap_sel_i];
        end
    end

endmodule

// File: tb/tb_fpga_dffer_pipe.sv
// Bench for fpga_dffer_pipe: DEPTH=4 and DEPTH=3 instances driven in lockstep,
// checked against a queue-based history model plus literal expectations.
module tb_fpga_dffer_pipe;

    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       E = 1'b0;
    logic       clr = 1'b0;
    logic       vin = 1'b0;
    logic [7:0] D = 8'h00;
    logic [1:0] sel4 = 2'd0;
    logic [1:0] sel3 = 2'd0;
    logic       chk_en = 1'b0;

    logic [7:0] Q4, T4, Q3, T3;
    logic       V4, TV4, V3, TV3;
    logic [2:0] F4;
    logic [1:0] F3;

    int errors = 0;
    int checks = 0;

    fpga_dffer_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV)) u4 (
        .clk_i(clk), .reset_i(rst), .E_i(E), .clr_i(clr), .D_i(D), .valid_i(vin),
        .tap_sel_i(sel4), .Q_o(Q4), .valid_o(V4), .tap_o(T4), .tap_valid_o(TV4), .fill_o(F4)
    );

    fpga_dffer_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(RV)) u3 (
        .clk_i(clk), .reset_i(rst), .E_i(E), .clr_i(clr), .D_i(D), .valid_i(vin),
        .tap_sel_i(sel3), .Q_o(Q3), .valid_o(V3), .tap_o(T3), .tap_valid_o(TV3), .fill_o(F3)
    );

    always #5 clk = ~clk;

    // Model: history of the last four accepted words, newest at index 0.
    logic [7:0] qd[$];
    logic       qv[$];

    task automatic m_flush();
        qd.delete();
        qv.delete();
        repeat (4) begin
            qd.push_back(RV);
            qv.push_back(1'b0);
        end
    endtask

    function automatic int pc(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(qv[i]);
        return s;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            m_flush();
        end else if (E) begin
            qd.push_front(D);
            qv.push_front(vin);
            void'(qd.pop_back());
            void'(qv.pop_back());
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("q4", 32'(Q4), 32'(qd[3]));
            chk("valid4", 32'(V4), 32'(qv[3]));
            chk("fill4", 32'(F4), pc(4));
            chk("tap4", 32'(T4), 32'(qd[sel4]));
            chk("tapv4", 32'(TV4), 32'(qv[sel4]));
            chk("q3", 32'(Q3), 32'(qd[2]));
            chk("valid3", 32'(V3), 32'(qv[2]));
            chk("fill3", 32'(F3), pc(3));
            chk("tap3", 32'(T3), (sel3 == 2'd3) ? 32'(RV) : 32'(qd[sel3]));
            chk("tapv3", 32'(TV3), (sel3 == 2'd3) ? 32'd0 : 32'(qv[sel3]));
        end
    end

    task automatic step(input logic [7:0] d, input logic v, input logic e, input logic c);
        D    = d;
        vin  = v;
        E    = e;
        clr  = c;
        sel4 = sel4 + 2'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_flush();
        rst = 1'b1;
        #2;
        chk("reset_q", 32'(Q4), 32'hA5);
        chk("reset_valid", 32'(V4), 32'd0);
        chk("reset_fill", 32'(F4), 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Streaming
        step(8'h01, 1, 1, 0); chk("stream_fill1", 32'(F4), 32'd1);
        step(8'h02, 1, 1, 0); chk("stream_fill2", 32'(F4), 32'd2);
        step(8'h03, 1, 1, 0); chk("stream_fill3", 32'(F4), 32'd3);
        step(8'h04, 1, 1, 0); chk("stream_fill4", 32'(F4), 32'd4);
        chk("stream_q01", 32'(Q4), 32'h01);
        chk("stream_v01", 32'(V4), 32'd1);
        step(8'h05, 1, 1, 0); chk("stream_fill5", 32'(F4), 32'd4);
        chk("stream_q02", 32'(Q4), 32'h02);
        step(8'h06, 1, 1, 0); chk("stream_q03", 32'(Q4), 32'h03);

        // Flush with enable and valid asserted
        step(8'hFF, 1, 1, 1);
        chk("flush_q", 32'(Q4), 32'hA5);
        chk("flush_valid", 32'(V4), 32'd0);
        chk("flush_fill", 32'(F4), 32'd0);
        chk("flush_q3", 32'(Q3), 32'hA5);

        // Stall: D toggles while disabled and must never enter the line
        step(8'h11, 1, 1, 0);
        step(8'h00, 1, 0, 0);
        step(8'hFF, 1, 0, 0);
        step(8'h00, 1, 0, 0);
        chk("stall_fill", 32'(F4), 32'd1);
        step(8'h22, 0, 1, 0);
        step(8'h22, 0, 1, 0);
        chk("stall_q_early", 32'(Q4), 32'hA5);
        step(8'h22, 0, 1, 0);
        chk("stall_q11", 32'(Q4), 32'h11);
        chk("stall_v11", 32'(V4), 32'd1);

        // Mid-cycle asynchronous reset on a partially filled line
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_q", 32'(Q4), 32'hA5);
        chk("midrst_valid", 32'(V4), 32'd0);
        chk("midrst_fill", 32'(F4), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Mixed valid pattern
        step(8'h31, 1, 1, 0);
        step(8'h32, 0, 1, 0);
        step(8'h33, 1, 1, 0);
        step(8'h34, 1, 1, 0);
        chk("mixed_fill", 32'(F4), 32'd3);
        chk("mixed_v", 32'(V4), 32'd1);
        chk("mixed_q", 32'(Q4), 32'h31);
        step(8'h35, 0, 1, 0);
        chk("mixed_v2", 32'(V4), 32'd0);
        step(8'h36, 1, 1, 0);
        step(8'h37, 0, 1, 0);
        step(8'h38, 0, 1, 0);
        step(8'h39, 1, 1, 0);
        step(8'h3A, 1, 1, 0);
        chk("mixed_fill2", 32'(F4), 32'd2);

        // Tap on the DEPTH=3 build: stages 0..2 hold 0A,0B,0C
        step(8'h00, 0, 0, 1);
        step(8'h0C, 1, 1, 0);
        step(8'h0B, 1, 1, 0);
        step(8'h0A, 1, 1, 0);
        E = 1'b0;
        sel3 = 2'd0; #1; chk("tap3_sel0", 32'(T3), 32'h0A);
        sel3 = 2'd1; #1; chk("tap3_sel1", 32'(T3), 32'h0B);
        sel3 = 2'd2; #1; chk("tap3_sel2", 32'(T3), 32'h0C);
        chk("tap3_v2", 32'(TV3), 32'd1);
        sel3 = 2'd3; #1; chk("tap3_sel3", 32'(T3), 32'hA5);
        chk("tap3_v3", 32'(TV3), 32'd0);
        step(8'h44, 1, 0, 0);
        step(8'h45, 1, 1, 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
